// File: rtl/connect4_board_engine.sv
// Connect4 board engine: stores the board, places dropped pieces, detects win/tie, and
// serves a registered display read port. Optional one-level undo when CONNECT4_UNDO_EN is defined.
module connect4_board_engine #(
    parameter int unsigned ROWS    = 6,
    parameter int unsigned COLS    = 7,
    parameter int unsigned WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] player,
    input  logic       drop_valid,
    input  logic [2:0] drop_col,
    input  logic       undo,
    output logic [1:0] game_status,
    output logic       invalid_column,
    output logic       col_full_err,
    output logic       busy,
    output logic       undo_done,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic [1:0] rd_cell
);
    localparam logic [2:0] MaxCol   = 3'(COLS - 1);
    localparam logic [2:0] MaxRow   = 3'(ROWS - 1);
    localparam logic [2:0] FullH    = 3'(ROWS);
    localparam logic [5:0] AllCells = 6'(ROWS * COLS);

    typedef enum logic [2:0] {StIdle, StPlace, StCheck, StReport, StDone} state_e;

    state_e                         state_q, state_d;
    logic [ROWS-1:0][COLS-1:0][1:0] board_q, board_d;
    logic [COLS-1:0][2:0]           height_q, height_d;
    logic [5:0]                     move_count_q, move_count_d;
    logic [2:0]                     cur_col_q, cur_col_d;
    logic [2:0]                     cur_row_q, cur_row_d;
    logic [1:0]                     cur_ply_q, cur_ply_d;
    logic [1:0]                     dir_q, dir_d;
    logic [1:0]                     game_status_q, game_status_d;
    logic                           invalid_column_q, invalid_column_d;
    logic                           col_full_err_q, col_full_err_d;
    logic                           busy_q, busy_d;
    logic [1:0]                     rd_cell_q, rd_cell_d;

`ifdef CONNECT4_UNDO_EN
    logic [2:0] last_col_q, last_col_d;
    logic [2:0] last_row_q, last_row_d;
    logic       last_valid_q, last_valid_d;
    logic       undo_done_q, undo_done_d;
`else
    logic unused_undo;
    assign unused_undo = undo;
`endif

    // Per-direction line length through the placed cell: h, v, /, \ in that order.
    logic [3:0] dir_win;
    int         step_r, step_c, run_len, pr, pc;
    logic       run_on;

    always_comb begin
        dir_win = '0;
        step_r  = 0;
        step_c  = 0;
        run_len = 0;
        pr      = 0;
        pc      = 0;
        run_on  = 1'b0;
        for (int d = 0; d < 4; d++) begin
            step_r  = (d == 0) ? 0 : 1;
            step_c  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
            run_len = 1;
            for (int s = -1; s <= 1; s += 2) begin
                run_on = 1'b1;
                for (int k = 1; k < int'(WIN_LEN); k++) begin
                    pr = int'(cur_row_q) + s * k * step_r;
                    pc = int'(cur_col_q) + s * k * step_c;
                    if (run_on && pr >= 0 && pr < int'(ROWS) && pc >= 0 && pc < int'(COLS)
                        && board_q[pr[2:0]][pc[2:0]] == cur_ply_q) begin
                        run_len++;
                    end else begin
                        run_on = 1'b0;
                    end
                end
            end
            dir_win[d[1:0]] = (run_len >= int'(WIN_LEN));
        end
    end

    always_comb begin
        state_d          = state_q;
        board_d          = board_q;
        height_d         = height_q;
        move_count_d     = move_count_q;
        cur_col_d        = cur_col_q;
        cur_row_d        = cur_row_q;
        cur_ply_d        = cur_ply_q;
        dir_d            = dir_q;
        game_status_d    = game_status_q;
        invalid_column_d = invalid_column_q;
        busy_d           = busy_q;
        col_full_err_d   = 1'b0;
`ifdef CONNECT4_UNDO_EN
        last_col_d       = last_col_q;
        last_row_d       = last_row_q;
        last_valid_d     = last_valid_q;
        undo_done_d      = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                game_status_d    = 2'b00;
                invalid_column_d = 1'b1;
                busy_d           = 1'b0;
`ifdef CONNECT4_UNDO_EN
                // Undo has priority; a simultaneous drop is discarded.
                if (undo) begin
                    if (last_valid_q) begin
                        board_d[last_row_q][last_col_q] = 2'b00;
                        height_d[last_col_q] = height_q[last_col_q] - 3'd1;
                        move_count_d = move_count_q - 6'd1;
                        last_valid_d = 1'b0;
                        undo_done_d  = 1'b1;
                    end
                end else
`endif
                if (drop_valid && (player == 2'b01 || player == 2'b10)) begin
                    if (drop_col > MaxCol) begin
                        col_full_err_d = 1'b1;
                    end else if (height_q[drop_col] == FullH) begin
                        col_full_err_d = 1'b1;
                    end else begin
                        cur_col_d = drop_col;
                        cur_row_d = height_q[drop_col];
                        cur_ply_d = player;
                        busy_d    = 1'b1;
                        state_d   = StPlace;
                    end
                end
            end
            StPlace: begin
                board_d[cur_row_q][cur_col_q] = cur_ply_q;
                height_d[cur_col_q] = height_q[cur_col_q] + 3'd1;
                if (move_count_q != AllCells) begin
                    move_count_d = move_count_q + 6'd1;
                end
`ifdef CONNECT4_UNDO_EN
                last_col_d   = cur_col_q;
                last_row_d   = cur_row_q;
                last_valid_d = 1'b1;
`endif
                dir_d   = 2'd0;
                state_d = StCheck;
            end
            StCheck: begin
                if (dir_win[dir_q] || dir_q == 2'd3) begin
                    state_d          = StReport;
                    busy_d           = 1'b0;
                    invalid_column_d = 1'b0;
                    if (dir_win[dir_q]) begin
                        game_status_d = 2'b01;
                    end else if (move_count_q == AllCells) begin
                        game_status_d = 2'b10;
                    end else begin
                        game_status_d = 2'b00;
                    end
                end else begin
                    dir_d = dir_q + 2'd1;
                end
            end
            StReport: begin
                invalid_column_d = 1'b1;
                state_d = (game_status_q == 2'b00) ? StIdle : StDone;
            end
            StDone: begin
                invalid_column_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_cell_d = 2'b00;
        if (rd_row <= MaxRow && rd_col <= MaxCol) begin
            rd_cell_d = board_q[rd_row][rd_col];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            board_q          <= '0;
            height_q         <= '0;
            move_count_q     <= '0;
            cur_col_q        <= '0;
            cur_row_q        <= '0;
            cur_ply_q        <= '0;
            dir_q            <= '0;
            game_status_q    <= 2'b00;
            invalid_column_q <= 1'b1;
            col_full_err_q   <= 1'b0;
            busy_q           <= 1'b0;
            rd_cell_q        <= 2'b00;
        end else begin
            state_q          <= state_d;
            board_q          <= board_d;
            height_q         <= height_d;
            move_count_q     <= move_count_d;
            cur_col_q        <= cur_col_d;
            cur_row_q        <= cur_row_d;
            cur_ply_q        <= cur_ply_d;
            dir_q            <= dir_d;
            game_status_q    <= game_status_d;
            invalid_column_q <= invalid_column_d;
            col_full_err_q   <= col_full_err_d;
            busy_q           <= busy_d;
            rd_cell_q        <= rd_cell_d;
        end
    end

`ifdef CONNECT4_UNDO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_col_q   <= '0;
            last_row_q   <= '0;
            last_valid_q <= 1'b0;
            undo_done_q  <= 1'b0;
        end else begin
            last_col_q   <= last_col_d;
            last_row_q   <= last_row_d;
            last_valid_q <= last_valid_d;
            undo_done_q  <= undo_done_d;
        end
    end

    assign undo_done = undo_done_q;
`else
    assign undo_done = 1'b0;
`endif

    assign game_status    = game_status_q;
    assign invalid_column = invalid_column_q;
    assign col_full_err   = col_full_err_q;
    assign busy           = busy_q;
    assign rd_cell        = rd_cell_q;

endmodule

// File: tb/tb_connect4_board_engine.sv
// Self-checking bench for connect4_board_engine: directed scenarios plus random games
// compared against a window-scanning board model.
module tb_connect4_board_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] player = 2'b00;
    logic       drop_valid = 1'b0;
    logic [2:0] drop_col = 3'd0;
    logic       undo = 1'b0;
    logic [1:0] game_status;
    logic       invalid_column, col_full_err, busy, undo_done;
    logic [2:0] rd_row = 3'd0, rd_col = 3'd0;
    logic [1:0] rd_cell;

    int checks = 0;
    int failures = 0;

    int mboard [6][7];
    int mcount;
    bit mdone;
    int mstatus;

    connect4_board_engine dut (
        .clk            (clk),
        .reset          (reset),
        .player         (player),
        .drop_valid     (drop_valid),
        .drop_col       (drop_col),
        .undo           (undo),
        .game_status    (game_status),
        .invalid_column (invalid_column),
        .col_full_err   (col_full_err),
        .busy           (busy),
        .undo_done      (undo_done),
        .rd_row         (rd_row),
        .rd_col         (rd_col),
        .rd_cell        (rd_cell)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mheight(input int c);
        int h;
        h = 0;
        for (int r = 0; r < 6; r++) if (mboard[r][c] != 0) h++;
        return h;
    endfunction

    // First direction (h, v, /, \) in which some 4-cell window through (r,c) is all p.
    function automatic int first_win_dir(input int r, input int c, input int p);
        int dr, dc, n, rr, cc;
        for (int d = 0; d < 4; d++) begin
            dr = (d == 0) ? 0 : 1;
            dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
            for (int off = 0; off < 4; off++) begin
                n = 0;
                for (int i = 0; i < 4; i++) begin
                    rr = r + (i - off) * dr;
                    cc = c + (i - off) * dc;
                    if (rr >= 0 && rr < 6 && cc >= 0 && cc < 7 && mboard[rr][cc] == p) n++;
                end
                if (n == 4) return d;
            end
        end
        return -1;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        drop_valid = 1'b0;
        undo = 1'b0;
        player = 2'b00;
        drop_col = 3'd0;
        rd_row = 3'd0;
        rd_col = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 6; r++) for (int c = 0; c < 7; c++) mboard[r][c] = 0;
        mcount = 0;
        mdone = 1'b0;
        mstatus = 0;
    endtask

    task automatic do_move(input logic [1:0] ply, input int col, input string tag);
        bit         accept, exp_err;
        int         row, dir, exp_lat, err_cnt, rep_at;
        logic [1:0] exp_st, rep_st;
        logic       busy1;
        accept  = !mdone && (ply == 2'b01 || ply == 2'b10) && col < 7 && mheight(col) < 6;
        exp_err = !mdone && (ply == 2'b01 || ply == 2'b10) && !accept;
        exp_lat = 0;
        exp_st  = 2'(mstatus);
        if (accept) begin
            row = mheight(col);
            mboard[row][col] = int'(ply);
            mcount++;
            dir = first_win_dir(row, col, int'(ply));
            exp_lat = (dir >= 0) ? 3 + dir : 6;
            exp_st  = (dir >= 0) ? 2'b01 : ((mcount == 42) ? 2'b10 : 2'b00);
            if (exp_st != 2'b00) begin
                mdone = 1'b1;
                mstatus = int'(exp_st);
            end
        end
        player = ply;
        drop_col = col[2:0];
        drop_valid = 1'b1;
        err_cnt = 0;
        rep_at = 0;
        rep_st = 2'b00;
        busy1 = 1'b0;
        for (int k = 1; k <= 8 && rep_at == 0; k++) begin
            @(negedge clk);
            drop_valid = 1'b0;
            if (k == 1) busy1 = busy;
            if (col_full_err) err_cnt++;
            if (!invalid_column) begin
                rep_at = k;
                rep_st = game_status;
            end
        end
        checks++;
        if (rep_at != exp_lat)
            $display("FAIL %s report_cycle: got %0d expected %0d (col %0d)", tag, rep_at, exp_lat, col);
        checks++;
        if (err_cnt != int'(exp_err))
            $display("FAIL %s col_full_err_pulses: got %0d expected %0d", tag, err_cnt, int'(exp_err));
        checks++;
        if (busy1 !== accept)
            $display("FAIL %s busy_after_drop: got %b expected %b", tag, busy1, accept);
        if (accept) begin
            checks++;
            if (rep_st !== exp_st)
                $display("FAIL %s status_at_report: got %b expected %b", tag, rep_st, exp_st);
            @(negedge clk);
        end
        checks++;
        if (invalid_column !== 1'b1 || game_status !== exp_st)
            $display("FAIL %s status_after: got inv=%b st=%b expected inv=1 st=%b", tag,
                     invalid_column, game_status, exp_st);
        if (!(accept && rep_at == exp_lat) && !(!accept && rep_at == 0)) failures++;
        else if (err_cnt != int'(exp_err) || busy1 !== accept) failures++;
        else if (accept && rep_st !== exp_st) failures++;
        else if (invalid_column !== 1'b1 || game_status !== exp_st) failures++;
    endtask

    task automatic test_readback(input int n);
        int r, c;
        logic [1:0] exp;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 7);
            c = $urandom_range(0, 7);
            rd_row = r[2:0];
            rd_col = c[2:0];
            exp = (r < 6 && c < 7) ? 2'(mboard[r][c]) : 2'b00;
            @(negedge clk);
            checks++;
            if (rd_cell !== exp) begin
                failures++;
                $display("FAIL readback (%0d,%0d): got %b expected %b", r, c, rd_cell, exp);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (game_status !== 2'b00 || invalid_column !== 1'b1 || col_full_err !== 1'b0 ||
            busy !== 1'b0 || undo_done !== 1'b0 || rd_cell !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: got st=%b inv=%b err=%b busy=%b ud=%b rd=%b expected 00 1 0 0 0 00",
                     game_status, invalid_column, col_full_err, busy, undo_done, rd_cell);
        end
        @(negedge clk);
        checks++;
        if (invalid_column !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got inv=%b busy=%b expected 1 0", invalid_column, busy);
        end
    endtask

    task automatic test_first_move();
        apply_reset();
        do_move(2'b01, 3, "first_move");
        rd_row = 3'd0;
        rd_col = 3'd3;
        @(negedge clk);
        checks++;
        if (rd_cell !== 2'b01) begin
            failures++;
            $display("FAIL first_move_read: got %b expected 01", rd_cell);
        end
    endtask

    task automatic test_horizontal_win();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_move(2'b01, i, "horiz_p1");
            do_move(2'b10, i, "horiz_p2");
        end
        do_move(2'b01, 3, "horiz_win");
        do_move(2'b10, 4, "horiz_after_done");
        checks++;
        if (game_status !== 2'b01 || busy !== 1'b0) begin
            failures++;
            $display("FAIL horiz_done_hold: got st=%b busy=%b expected 01 0", game_status, busy);
        end
        test_readback(6);
    endtask

    task automatic test_col_full();
        apply_reset();
        for (int i = 0; i < 6; i++) do_move((i % 2 == 0) ? 2'b01 : 2'b10, 5, "col5_fill");
        do_move(2'b01, 5, "col5_full");
        do_move(2'b10, 7, "col7_range");
        do_move(2'b00, 2, "no_player");
        do_move(2'b11, 2, "bad_player");
        rd_row = 3'd5;
        rd_col = 3'd5;
        @(negedge clk);
        checks++;
        if (rd_cell !== 2'b10) begin
            failures++;
            $display("FAIL col5_top_read: got %b expected 10", rd_cell);
        end
        test_readback(8);
    endtask

    task automatic test_vertical_diag();
        apply_reset();
        for (int i = 0; i < 4; i++) do_move(2'b01, 6, "vertical");
        checks++;
        if (game_status !== 2'b01) begin
            failures++;
            $display("FAIL vertical_status: got %b expected 01", game_status);
        end
        apply_reset();
        do_move(2'b01, 0, "diag");
        do_move(2'b10, 1, "diag");
        do_move(2'b01, 1, "diag");
        do_move(2'b10, 2, "diag");
        do_move(2'b10, 2, "diag");
        do_move(2'b01, 2, "diag");
        do_move(2'b10, 3, "diag");
        do_move(2'b10, 3, "diag");
        do_move(2'b10, 3, "diag");
        do_move(2'b01, 3, "diag_win");
        checks++;
        if (game_status !== 2'b01) begin
            failures++;
            $display("FAIL diag_status: got %b expected 01", game_status);
        end
    endtask

    task automatic fill_board(input bit make_win, input string tag);
        int f;
        apply_reset();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 7; c++) begin
                f = ((c / 2) + r) % 2;
                if (make_win && r == 5) f = (c < 3) ? 1 : 0;
                do_move(2'(f + 1), c, tag);
            end
        end
    endtask

    task automatic test_full_board();
        fill_board(1'b0, "tie_fill");
        checks++;
        if (game_status !== 2'b10 || invalid_column !== 1'b1) begin
            failures++;
            $display("FAIL tie_status: got st=%b inv=%b expected 10 1", game_status, invalid_column);
        end
        do_move(2'b01, 0, "tie_after_done");
        test_readback(6);
        fill_board(1'b1, "winfill");
        checks++;
        if (game_status !== 2'b01) begin
            failures++;
            $display("FAIL last_move_win_status: got %b expected 01", game_status);
        end
    endtask

    task automatic test_random();
        int col;
        logic [1:0] ply;
        for (int g = 0; g < 4; g++) begin
            apply_reset();
            for (int m = 0; m < 50 && !mdone; m++) begin
                col = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 6));
                ply = ($urandom_range(0, 9) == 0) ? 2'b00 : ((m % 2 == 1) ? 2'b10 : 2'b01);
                do_move(ply, col, "random");
                if (m % 8 == 7) test_readback(2);
            end
            if (mdone) do_move(2'b01, int'($urandom_range(0, 6)), "random_done");
            test_readback(10);
        end
    endtask

    task automatic test_undo();
        apply_reset();
        do_move(2'b01, 2, "undo_setup");
        rd_row = 3'd0;
        rd_col = 3'd2;
        undo = 1'b1;
        @(negedge clk);
        undo = 1'b0;
`ifdef CONNECT4_UNDO_EN
        mboard[0][2] = 0;
        mcount--;
        checks++;
        if (undo_done !== 1'b1) begin
            failures++;
            $display("FAIL undo_done_pulse: got %b expected 1", undo_done);
        end
        @(negedge clk);
        checks++;
        if (undo_done !== 1'b0 || rd_cell !== 2'b00 || invalid_column !== 1'b1) begin
            failures++;
            $display("FAIL undo_cleared: got ud=%b rd=%b inv=%b expected 0 00 1",
                     undo_done, rd_cell, invalid_column);
        end
        undo = 1'b1;
        @(negedge clk);
        undo = 1'b0;
        checks++;
        if (undo_done !== 1'b0) begin
            failures++;
            $display("FAIL second_undo: got %b expected 0", undo_done);
        end
        do_move(2'b10, 2, "undo_redrop");
        do_move(2'b01, 3, "undo_setup2");
        undo = 1'b1;
        drop_valid = 1'b1;
        player = 2'b10;
        drop_col = 3'd0;
        @(negedge clk);
        undo = 1'b0;
        drop_valid = 1'b0;
        mboard[0][3] = 0;
        mcount--;
        checks++;
        if (undo_done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL undo_beats_drop: got ud=%b busy=%b expected 1 0", undo_done, busy);
        end
        @(negedge clk);
`else
        checks++;
        if (undo_done !== 1'b0 || rd_cell !== 2'b01) begin
            failures++;
            $display("FAIL undo_disabled: got ud=%b rd=%b expected 0 01", undo_done, rd_cell);
        end
        @(negedge clk);
        checks++;
        if (undo_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL undo_disabled_idle: got ud=%b busy=%b expected 0 0", undo_done, busy);
        end
`endif
        test_readback(8);
    endtask

    task automatic test_reset_mid_move();
        apply_reset();
        do_move(2'b01, 0, "midreset_setup");
        player = 2'b10;
        drop_col = 3'd4;
        drop_valid = 1'b1;
        @(negedge clk);
        drop_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (invalid_column !== 1'b1 || busy !== 1'b0 || game_status !== 2'b00) begin
            failures++;
            $display("FAIL async_reset_in_check: got inv=%b busy=%b st=%b expected 1 0 00",
                     invalid_column, busy, game_status);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 6; r++) for (int c = 0; c < 7; c++) mboard[r][c] = 0;
        mcount = 0;
        mdone = 1'b0;
        mstatus = 0;
        rd_row = 3'd0;
        rd_col = 3'd0;
        @(negedge clk);
        checks++;
        if (rd_cell !== 2'b00) begin
            failures++;
            $display("FAIL midreset_board_clear: got %b expected 00", rd_cell);
        end
        do_move(2'b10, 4, "midreset_redrop");
        test_readback(6);
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_horizontal_win();
        test_col_full();
        test_vertical_diag();
        test_full_board();
        test_undo();
        test_reset_mid_move();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/connect4_board_engine.md
Name: connect4_board_engine

Overview:
- Board-side move engine for Connect4: stores the board, accepts column drops from the current player, and places pieces. Performs win and tie detection.
- Produces the `game_status` and `invalid_column` signals consumed by the game turn FSM. This block is the producer end of that status interface; it takes the FSM's current player as its `player` input.
- Also provides a registered cell read port for the display logic.

Parameters:
- ROWS, 6, board rows; row 0 is the bottom.
- COLS, 7, board columns; must be ≤ 8.
- WIN_LEN, 4, number of contiguous same-colour pieces needed to win.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- player  input  2  current turn: 01 = P1, 10 = P2; 00 and 11 = no player.
- drop_valid  input  1  single-cycle request to drop a piece.
- drop_col  input  3  target column, 0..COLS-1.
- undo  input  1  single-cycle undo request; used only when CONNECT4_UNDO_EN is defined.
- game_status  output  2  00 = NEXT_TURN, 01 = PLAYER_WIN, 10 = TIE_GAME.
- invalid_column  output  1  1 = no accepted move to report (hold turn); 0 = status valid this cycle.
- col_full_err  output  1  one-cycle pulse when a drop is rejected.
- busy  output  1  engine is processing a move.
- undo_done  output  1  one-cycle pulse when an undo completes.
- rd_row  input  3  display read row.
- rd_col  input  3  display read column.
- rd_cell  output  2  registered cell contents: 00 empty, 01 P1, 10 P2.

Behaviour:
- Reset (asynchronous):
  - All cells are set to 00, all column heights to 0, and move_count to 0.
  - Outputs: game_status = 00, invalid_column = 1, col_full_err = 0, busy = 0, undo_done = 0, rd_cell = 00.
  - State = IDLE.
  - Reset asserted mid-move aborts the move; no partial placement survives.
- States: IDLE, PLACE, CHECK, REPORT, DONE.
- IDLE:
  - drop_valid is accepted only when player is 01 or 10. Drops with player 00 or 11 are ignored with no error.
  - If drop_col ≥ COLS or height[drop_col] == ROWS: pulse col_full_err for 1 cycle, stay in IDLE, keep invalid_column = 1.
  - Otherwise latch the column, row = height[col], and the player, then go to PLACE. busy = 1 from the next cycle.
- PLACE (1 cycle): write the player code into cell[row][col], increment height[col], increment move_count.
- CHECK (4 cycles, one per direction, in the order horizontal, vertical, diagonal /, diagonal \):
  - Count contiguous same-colour cells starting from the placed cell, stepping up to WIN_LEN-1 cells each way. Stop at the board edge or at a mismatching cell.
  - The count includes the placed cell.
  - If count ≥ WIN_LEN, set win_flag and go straight to REPORT, skipping the remaining directions.
- REPORT (1 cycle):
  - invalid_column = 0 and busy = 0.
  - game_status = 01 if win_flag is set; else 10 if move_count == ROWS*COLS; else 00.
  - A win takes precedence over a tie on the final move.
  - Next state is DONE if the status is 01 or 10, else IDLE.
- IDLE after REPORT: invalid_column returns to 1 and game_status returns to 00.
- DONE: game_status holds 01 or 10 and invalid_column = 1. drop_valid and undo are ignored until reset.
- Move latency: 3 to 6 cycles from accepted drop_valid to the REPORT cycle, depending on which direction finds a win. Exactly 6 cycles when there is no win.
- drop_valid or undo asserted while busy or in REPORT is ignored (no queueing) and does not raise col_full_err.
- Read port: rd_cell <= cell[rd_row][rd_col], registered with 1-cycle latency. Out-of-range addresses return 00. Reads never stall the engine.
- Widths:
  - height: 3 bits per column.
  - move_count: 6 bits, saturating at ROWS*COLS.

Optional Feature:
- Macro: CONNECT4_UNDO_EN.
- Defined:
  - Track the last placed position (col, row) with a last_valid flag. last_valid is set in PLACE and cleared by an undo or by reset.
  - undo in IDLE with last_valid = 1: in the next cycle, clear that cell, decrement height and move_count, clear last_valid, and pulse undo_done for 1 cycle. game_status and invalid_column are unchanged.
  - undo with last_valid = 0, or while in DONE: ignored.
  - Only one level of undo is supported.
  - If undo and drop_valid are asserted in the same cycle, undo wins and the drop is dropped.
- Undefined: the undo input is ignored, undo_done is tied to 0, and no last-move registers are built.

Test Plan:
- Reset, then drop col 3 with player 01 → 6 cycles later a 1-cycle invalid_column = 0 with game_status = 00; rd (0,3) returns 01.
- Alternate P1 cols 0,1,2,3 with P2 cols 0,1,2 → at P1's col 3 drop, REPORT gives game_status = 01; engine enters DONE; a further drop is ignored and status stays 01.
- Drop col 5 six times, then a 7th drop → col_full_err pulses, invalid_column stays 1, height[5] = 6. A drop to col 7 also pulses col_full_err.
- Vertical and diagonal wins: 4 pieces stacked in col 6 → 01 after 4 cycles (PLACE + 2 CHECK + REPORT). A / diagonal from (0,0) to (3,3) → win detected on the 3rd CHECK cycle.
- Fill 42 cells with no line of 4 → 42nd move reports 10. Same fill with the final move completing a line → reports 01.
- With CONNECT4_UNDO_EN defined: drop col 2, undo → undo_done pulses, cell (0,2) reads 00, height[2] = 0; a second undo has no effect. Also assert reset during CHECK → board clears and invalid_column = 1.
